fpga_status_led_ctrl: RTL
=========================

FPGA_STATUS_LED_CTRL -- requirements
Module: fpga_status_led_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 4, number of general status LED channels (1..16).
REQ-002 SHALL have parameter TICK_DIV, default 1000000, clk_i cycles per timing tick (>=2).
REQ-003 SHALL have parameter EXIT_W, default 32, width of exit_value_i.
REQ-004 SHALL have port clk_i, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_i, input, 1, reset: synchronous, active-high.
REQ-006 SHALL have port mode_i, input, 2*NUM_LEDS, per-channel mode: 00 off, 01 on, 10 blink, 11 event-stretch; bits [2k+1:2k] select channel k.
REQ-007 SHALL have port half_period_i, input, 8, blink half-period in ticks.
REQ-008 SHALL have port event_i, input, NUM_LEDS, single-cycle event pulses for stretch mode.
REQ-009 SHALL have port stretch_len_i, input, 8, stretch on-time in ticks.
REQ-010 SHALL have port exit_valid_i, input, 1, program-exit status valid (level).
REQ-011 SHALL have port exit_value_i, input, EXIT_W, program exit code.
REQ-012 SHALL have port led_o, output, NUM_LEDS, registered status LED drives.
REQ-013 SHALL have port exit_led_o, output, 1, registered exit-code LED drive.
REQ-014 SHALL have port tick_o, output, 1, one-cycle pulse per timing tick.

Function
REQ-015 SHALL count a prescaler 0..TICK_DIV-1 and wrap to 0, with tick_o high for exactly the cycle the count equals TICK_DIV-1.
REQ-016 SHALL keep one shared blink phase: a tick counter that toggles the phase bit and clears on the tick when it reaches max(half_period_i,1)-1, so half_period_i=0 behaves as 1.
REQ-017 SHALL drive led_o[k] one cycle after inputs: mode 00 -> 0; 01 -> 1; 10 -> blink phase; 11 -> (stretch counter k != 0).
REQ-018 SHALL load stretch counter k with max(stretch_len_i,1) when event_i[k]=1 and mode is 11, retriggering if already nonzero; otherwise it decrements on each tick while nonzero.
REQ-019 SHALL give a load priority over a decrement when event_i[k] and tick_o coincide.
REQ-020 SHALL clear stretch counter k in any cycle in which channel k's mode is not 11, and ignore events in that cycle.
REQ-021 SHALL run the exit FSM with states IDLE, SOLID, ON, OFF, GAP, advancing only on ticks except as stated.
REQ-022 IDLE: exit_led_o=0; on the first cycle with exit_valid_i=1, latch the code, set blink count N=min(code,15), and go to SOLID if the code is 0, else to ON; both moves are immediate, not tick-gated.
REQ-023 SOLID: exit_led_o=1.
REQ-024 ON: exit_led_o=1 for 1 tick, then go to OFF.
REQ-025 OFF: exit_led_o=0 for 1 tick, then increment the blink index; go to GAP if index=N, else go to ON.
REQ-026 GAP: exit_led_o=0 for 4 ticks, then clear the index and go to ON; repeat indefinitely.
REQ-027 SHALL ignore changes to exit_value_i while exit_valid_i stays high.
REQ-028 SHALL send the FSM to IDLE in the cycle after exit_valid_i falls in any state, so exit_led_o=0 and the index clears.
REQ-029 SHALL take exit_led_o from the registered FSM state, so it is valid one cycle after the state is entered.

Reset
REQ-030 SHALL, while rst_i=1 at a clk_i edge, clear the prescaler, blink counter, blink phase, all stretch counters and the blink index, and put the FSM in IDLE.
REQ-031 SHALL hold led_o=0, exit_led_o=0 and tick_o=0 during reset and in the first cycle after it.
REQ-032 SHALL apply reset mid-operation (mid-stretch, mid-blink) within one cycle and discard the latched exit code.

Verification (TICK_DIV=4, NUM_LEDS=4)
REQ-033 Reset release, all modes 00: tick_o pulses every 4th cycle, first pulse 4 cycles after release; led_o=0000.
REQ-034 mode ch0=10, half_period_i=2: led_o[0] toggles every 8 cycles; with half_period_i=0 it toggles every 4 cycles.
REQ-035 mode ch1=11, stretch_len_i=3, one event: led_o[1] high from the next cycle until the third subsequent tick; a second event before expiry restarts the 3-tick count.
REQ-036 Event on the same cycle as a tick: counter loads 3 with no decrement; a mode change of ch1 to 00 mid-stretch gives led_o[1]=0 on the next cycle, and the old stretch does not resume on return to 11.
REQ-037 exit_valid_i=1, exit_value_i=3: exit_led_o runs 3x(1 tick on, 1 tick off), then 4 ticks off, repeating; exit_value_i=0 gives solid 1; 0x20 gives 15 blinks; dropping exit_valid_i gives 0 the next cycle.
REQ-038 rst_i asserted mid-GAP and mid-stretch: all outputs 0 the next cycle; after release, exit_valid_i still high re-latches the current exit_value_i.

Source files
------------

// File: rtl/fpga_status_led_ctrl.sv
// Status LED controller: shared tick prescaler, per-channel off/on/blink/event-stretch
// drives, and an exit-code LED that blinks min(code,15) times followed by a long gap.
module fpga_status_led_ctrl #(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 1000000,
    parameter int EXIT_W   = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [2*NUM_LEDS-1:0]   mode_i,
    input  logic [7:0]              half_period_i,
    input  logic [NUM_LEDS-1:0]     event_i,
    input  logic [7:0]              stretch_len_i,
    input  logic                    exit_valid_i,
    input  logic [EXIT_W-1:0]       exit_value_i,
    output logic [NUM_LEDS-1:0]     led_o,
    output logic                    exit_led_o,
    output logic                    tick_o
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SOLID = 3'd1,
        ST_ON    = 3'd2,
        ST_OFF   = 3'd3,
        ST_GAP   = 3'd4
    } exit_state_t;

    logic [PW-1:0]         presc_r, presc_s;
    logic                  tick_r, tick_s;
    logic [7:0]            blink_cnt_r, blink_cnt_s;
    logic [7:0]            hp_last_s;
    logic                  phase_r, phase_s;
    logic [7:0]            str_r [NUM_LEDS];
    logic [7:0]            str_s [NUM_LEDS];
    logic [7:0]            str_load_s;
    logic [NUM_LEDS-1:0]   led_r, led_s;
    exit_state_t           state_r, state_s;
    logic [3:0]            idx_r, idx_s;
    logic [3:0]            n_r, n_s;
    logic [1:0]            gap_r, gap_s;
    logic                  exit_led_r, exit_led_s;

    // Prescaler and shared blink phase; tick_r is aligned with the cycle the count is at its maximum.
    always_comb begin
        presc_s     = presc_r;
        blink_cnt_s = blink_cnt_r;
        phase_s     = phase_r;
        hp_last_s   = (half_period_i == 8'd0) ? 8'd0 : (half_period_i - 8'd1);
        if (presc_r == PRESC_MAX) begin
            presc_s = {PW{1'b0}};
        end else begin
            presc_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
        end
        tick_s = (presc_s == PRESC_MAX);
        if (tick_r) begin
            if (blink_cnt_r >= hp_last_s) begin
                blink_cnt_s = 8'd0;
                phase_s     = ~phase_r;
            end else begin
                blink_cnt_s = blink_cnt_r + 8'd1;
            end
        end else begin
            blink_cnt_s = blink_cnt_r;
        end
    end

    // Per-channel stretch counters and LED drive; LEDs follow the next-state values.
    always_comb begin
        str_load_s = (stretch_len_i == 8'd0) ? 8'd1 : stretch_len_i;
        led_s      = {NUM_LEDS{1'b0}};
        for (int k = 0; k < NUM_LEDS; k++) begin
            str_s[k] = 8'd0;
            case (mode_i[2*k +: 2])
                2'b00: led_s[k] = 1'b0;
                2'b01: led_s[k] = 1'b1;
                2'b10: led_s[k] = phase_s;
                2'b11: begin
                    if (event_i[k]) begin
                        str_s[k] = str_load_s;
                    end else if (tick_r && (str_r[k] != 8'd0)) begin
                        str_s[k] = str_r[k] - 8'd1;
                    end else begin
                        str_s[k] = str_r[k];
                    end
                    led_s[k] = (str_s[k] != 8'd0);
                end
                default: led_s[k] = 1'b0;
            endcase
        end
    end

    // Exit-code FSM next state; a dropped valid overrides every state.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        n_s     = n_r;
        gap_s   = gap_r;
        if (!exit_valid_i) begin
            state_s = ST_IDLE;
            idx_s   = 4'd0;
            gap_s   = 2'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idx_s = 4'd0;
                    gap_s = 2'd0;
                    n_s   = (exit_value_i > EXIT_W'(32'd15)) ? 4'd15 : exit_value_i[3:0];
                    if (exit_value_i == {EXIT_W{1'b0}}) begin
                        state_s = ST_SOLID;
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_SOLID: state_s = ST_SOLID;
                ST_ON: begin
                    if (tick_r) begin
                        state_s = ST_OFF;
                    end else begin
                        state_s = ST_ON;
                    end
                end
                ST_OFF: begin
                    if (tick_r) begin
                        idx_s = idx_r + 4'd1;
                        if ((idx_r + 4'd1) == n_r) begin
                            state_s = ST_GAP;
                            gap_s   = 2'd0;
                        end else begin
                            state_s = ST_ON;
                        end
                    end else begin
                        state_s = ST_OFF;
                    end
                end
                ST_GAP: begin
                    if (tick_r) begin
                        if (gap_r == 2'd3) begin
                            gap_s   = 2'd0;
                            idx_s   = 4'd0;
                            state_s = ST_ON;
                        end else begin
                            gap_s = gap_r + 2'd1;
                        end
                    end else begin
                        state_s = ST_GAP;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    idx_s   = 4'd0;
                    gap_s   = 2'd0;
                end
            endcase
        end
        exit_led_s = (state_s == ST_ON) || (state_s == ST_SOLID);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_r     <= {PW{1'b0}};
            tick_r      <= 1'b0;
            blink_cnt_r <= 8'd0;
            phase_r     <= 1'b0;
            for (int k = 0; k < NUM_LEDS; k++) begin
                str_r[k] <= 8'd0;
            end
            led_r       <= {NUM_LEDS{1'b0}};
            state_r     <= ST_IDLE;
            idx_r       <= 4'd0;
            n_r         <= 4'd0;
            gap_r       <= 2'd0;
            exit_led_r  <= 1'b0;
        end else begin
            presc_r     <= presc_s;
            tick_r      <= tick_s;
            blink_cnt_r <= blink_cnt_s;
            phase_r     <= phase_s;
            for (int k = 0; k < NUM_LEDS; k++) begin
                str_r[k] <= str_s[k];
            end
            led_r       <= led_s;
            state_r     <= state_s;
            idx_r       <= idx_s;
            n_r         <= n_s;
            gap_r       <= gap_s;
            exit_led_r  <= exit_led_s;
        end
    end

    assign led_o      = led_r;
    assign exit_led_o = exit_led_r;
    assign tick_o     = tick_r;

endmodule
